// File: rtl/down_counter.sv
// rtl/down_counter.sv - pushbutton-driven down counter with prescaled tick and LED status output
// Optional auto-reload at terminal count is enabled by defining DOWN_COUNTER_AUTORELOAD_EN.
module down_counter #(
  parameter int unsigned DIV = 50000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  logic clk;
  logic rst_n;
  assign clk   = MAX10_CLK1_50;
  assign rst_n = KEY[1];

  logic sync1, sync2, sync3;
  logic started, armed;
  logic press;

  // armed stays low until the key has been seen released after reset, so a
  // button already held while reset lifts cannot fake a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync3   <= 1'b1;
      started <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync1   <= KEY[0];
      sync2   <= sync1;
      sync3   <= sync2;
      started <= 1'b1;
      armed   <= armed | (started & sync1);
    end
  end

  assign press = armed & sync3 & ~sync2;

  state_t        state, state_n;
  logic [9:0]    count, count_n;
  logic [PW-1:0] presc, presc_n;
  logic [9:0]    ledr_n;
  logic          tick;

  assign tick = (presc == PRESC_MAX);

  always_comb begin
    state_n = state;
    count_n = count;
    presc_n = presc;
    case (state)
      IDLE: begin
        if (press) begin
          count_n = SW;
          presc_n = '0;
          state_n = (SW == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (press) begin
          state_n = PAUSE;
        end else if (tick) begin
          presc_n = '0;
          if (count <= 10'd1) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            if (SW != '0) begin
              count_n = SW;
            end else begin
              count_n = '0;
              state_n = DONE;
            end
`else
            count_n = '0;
            state_n = DONE;
`endif
          end else begin
            count_n = count - 10'd1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (press) state_n = RUN;
      end
      DONE: begin
        if (press) begin
          state_n = IDLE;
          count_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ledr_n = 10'h000;
    case (state_n)
      RUN, PAUSE: ledr_n = count_n;
      DONE:       ledr_n = 10'h3FF;
      default:    ledr_n = 10'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      presc <= '0;
      LEDR  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      presc <= presc_n;
      LEDR  <= ledr_n;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - scoreboard bench for down_counter with DIV=4
module tb_down_counter;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [9:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] last_ledr = 10'h000;

  down_counter #(.DIV(4)) dut (
    .MAX10_CLK1_50(clk),
    .KEY          (key),
    .SW           (sw),
    .LEDR         (ledr)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every LEDR change must match the next queued step in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (key[1] !== 1'b1) begin
      last_ledr = ledr;
    end else if (ledr !== last_ledr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc=%0d ledr=%h, required no change from %h", cyc, ledr, last_ledr);
      end else begin
        e = sb.pop_front();
        if (ledr !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL ledr_step: got ledr=%h at cyc=%0d, required ledr=%h at cyc=%0d", ledr, cyc, e.val, e.cyc);
        end
      end
      last_ledr = ledr;
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_at(input int c, input logic [9:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pin falls just after edge c; the FSM acts on edge c+3.
  task automatic press_at(input int c);
    wait_cyc(c);
    key[0] = 1'b0;
    wait_cyc(c + 3);
    key[0] = 1'b1;
  endtask

  task automatic drain(input string name, input int c);
    wait_cyc(c);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected steps not seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    #4 key[1] = 1'b0;
    #2 check("reset_ledr", ledr, 10'h000);
    @(posedge clk);
    @(posedge clk);
    #5 key[1] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100 us");
    $fatal(1);
  end

  initial begin
    int b, p, r;
    key = 2'b01;
    sw  = 10'h000;
    repeat (2) @(posedge clk);
    #1 check("reset_state", ledr, 10'h000);
    #4 key[1] = 1'b1;
    @(posedge clk);
    #1;

    // SW=3 countdown, SW wiggled mid-run, then DONE -> IDLE
    b = cyc + 2; p = b + 3; sw = 10'd3;
    expect_at(p, 10'd3); expect_at(p + 4, 10'd2); expect_at(p + 8, 10'd1); expect_at(p + 12, 10'h3FF);
    press_at(b);
    sw = 10'h155;
    wait_cyc(p + 10);
    sw = 10'h000;
    drain("count3", p + 16);
    b = cyc + 1;
    expect_at(b + 3, 10'h000);
    press_at(b);
    drain("done_to_idle", b + 8);
    do_reset();

    // SW=5 with a 20-cycle pause and resume from the frozen prescaler
    b = cyc + 2; p = b + 3; r = p + 27; sw = 10'd5;
    expect_at(p, 10'd5); expect_at(p + 4, 10'd4);
    press_at(b);
    press_at(p + 4);
    wait_cyc(r - 4);
    check("pause_hold", ledr, 10'd4);
    expect_at(r + 2, 10'd3); expect_at(r + 6, 10'd2); expect_at(r + 10, 10'd1); expect_at(r + 14, 10'h3FF);
    press_at(r - 3);
    sw = 10'h000;
    drain("pause_resume", r + 18);
    do_reset();

    // SW=0 goes straight to DONE, next press back to IDLE
    b = cyc + 2; sw = 10'd0;
    expect_at(b + 3, 10'h3FF); expect_at(b + 9, 10'h000);
    press_at(b);
    press_at(b + 6);
    drain("zero_load", b + 14);
    do_reset();

    // Press lands on the same edge as a tick: no decrement, PAUSE
    b = cyc + 2; p = b + 3; sw = 10'd2;
    expect_at(p, 10'd2);
    press_at(b);
    press_at(b + 4);
    drain("press_tick", p + 16);
    check("press_tick_hold", ledr, 10'd2);
    do_reset();

    // Asynchronous reset mid-run, no counting afterwards
    b = cyc + 2; p = b + 3; sw = 10'd5;
    expect_at(p, 10'd5); expect_at(p + 4, 10'd4);
    press_at(b);
    wait_cyc(p + 6);
    #4 key[1] = 1'b0;
    #2 check("async_reset", ledr, 10'h000);
    wait_cyc(p + 8);
    #4 key[1] = 1'b1;
    drain("reset_mid_run", p + 30);
    check("idle_after_reset", ledr, 10'h000);

    // Key held through reset release must not produce a press
    #4 key[1] = 1'b0;
    key[0] = 1'b0;
    wait_cyc(cyc + 2);
    #4 key[1] = 1'b1;
    wait_cyc(cyc + 8);
    key[0] = 1'b1;
    wait_cyc(cyc + 10);
    check("held_press_ignored", ledr, 10'h000);
    b = cyc + 1; sw = 10'd1;
    expect_at(b + 3, 10'd1); expect_at(b + 7, 10'h3FF);
    press_at(b);
    sw = 10'h000;
    drain("press_after_held", b + 10);
    do_reset();

    // SW=2 run-out: terminal or auto-reloading depending on build
    b = cyc + 2; p = b + 3; sw = 10'd2;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    for (int k = 0; k <= 10; k++) expect_at(p + 4 * k, (k % 2 == 0) ? 10'd2 : 10'd1);
    press_at(b);
    drain("autoreload", p + 42);
`else
    expect_at(p, 10'd2); expect_at(p + 4, 10'd1); expect_at(p + 8, 10'h3FF);
    press_at(b);
    drain("count2", p + 12);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
